// File: rtl/tcp_offpath_pkg.sv
// tcp_offpath_pkg: shared notification layout, beat sizing and scheduler states
// for the off-path TCP wrapper.
package tcp_offpath_pkg;
    localparam int NOTIF_W     = 88;
    localparam int SESSION_LSB = 0;
    localparam int SESSION_W   = 16;
    localparam int LEN_LSB     = 16;
    localparam int LEN_W       = 16;
    localparam int BEAT_BYTES  = 64;
    localparam int BEAT_SHIFT  = $clog2(BEAT_BYTES);
    localparam int BEATS_W     = 11;

    typedef enum logic [1:0] {IDLE, CHECK, ISSUE} sched_state_t;

    // 17-bit sum so a 65535-byte payload rounds up to 1024 beats without overflow
    function automatic logic [BEATS_W-1:0] len_to_beats(input logic [LEN_W-1:0] len);
        logic [LEN_W:0] sum;
        sum = {1'b0, len} + (LEN_W+1)'(BEAT_BYTES - 1);
        return BEATS_W'(sum >> BEAT_SHIFT);
    endfunction
endpackage

// File: rtl/sched_notif_fifo.sv
// sched_notif_fifo: synchronous first-word-fall-through FIFO holding queued
// TOE notifications; o_data always shows the head entry when not empty.
module sched_notif_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 88
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr;
    logic             w_rd;

    assign o_empty = r_wr_ptr == r_rd_ptr;
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr    = i_wr && !o_full;
    assign w_rd    = i_rd && !o_empty;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + (AW+1)'(w_wr);
            r_rd_ptr <= r_rd_ptr + (AW+1)'(w_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/tcp_rx_read_scheduler.sv
// tcp_rx_read_scheduler: queues TOE notifications and issues one read_package
// request plus app metadata per notification once the RX buffer has room.
module tcp_rx_read_scheduler
    import tcp_offpath_pkg::*;
#(
    parameter int BUF_BEATS   = 4096,
    parameter int NOTIF_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           enable,
    input  logic                           s_notif_valid,
    output logic                           s_notif_ready,
    input  logic [87:0]                    s_notif_data,
    output logic                           m_read_pkg_valid,
    input  logic                           m_read_pkg_ready,
    output logic [31:0]                    m_read_pkg_data,
    output logic                           m_meta_valid,
    input  logic                           m_meta_ready,
    output logic [87:0]                    m_meta_data,
    input  logic                           rx_beat_consumed,
    output logic [$clog2(BUF_BEATS+1)-1:0] credits,
    output logic [31:0]                    stall_cycles,
    output logic [31:0]                    zero_len_drops,
    output logic                           credit_err
);
    localparam int CW = $clog2(BUF_BEATS + 1);

    sched_state_t       r_state;
    sched_state_t       w_state_nxt;
    logic [NOTIF_W-1:0] r_head;
    logic [BEATS_W-1:0] r_beats;
    logic               r_rd_pend;
    logic               r_meta_pend;
    logic [CW-1:0]      r_credits;
    logic [31:0]        r_stall_cycles;
    logic [31:0]        r_zero_len_drops;
    logic               r_credit_err;

    logic [NOTIF_W-1:0] w_fifo_data;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic [LEN_W-1:0]   w_len;
    logic               w_zero;
    logic               w_fits;
    logic               w_debit;
    logic               w_stall;
    logic               w_rd_hs;
    logic               w_meta_hs;
    logic [CW:0]        w_cred_sum;
    logic               w_sat;

    sched_notif_fifo #(.DEPTH(NOTIF_DEPTH), .WIDTH(NOTIF_W)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_wr    (s_notif_valid && s_notif_ready),
        .i_data  (s_notif_data),
        .i_rd    (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign s_notif_ready    = rstn && !w_full;
    assign w_pop            = (r_state == IDLE) && enable && !w_empty;
    assign w_len            = r_head[LEN_LSB +: LEN_W];
    assign w_zero           = w_len == '0;
    assign w_fits           = CW'(r_beats) <= r_credits;
    assign w_debit          = (r_state == CHECK) && !w_zero && w_fits;
    assign w_stall          = (r_state == CHECK) && !w_zero && !w_fits;
    // Valids are gated by reset so they drop in the very cycle reset is asserted
    assign m_read_pkg_valid = rstn && r_rd_pend;
    assign m_meta_valid     = rstn && r_meta_pend;
    assign m_read_pkg_data  = {w_len, r_head[SESSION_LSB +: SESSION_W]};
    assign m_meta_data      = r_head;
    assign w_rd_hs          = m_read_pkg_valid && m_read_pkg_ready;
    assign w_meta_hs        = m_meta_valid && m_meta_ready;
    assign w_cred_sum       = {1'b0, r_credits} - (w_debit ? (CW+1)'(r_beats) : '0)
                              + (CW+1)'(rx_beat_consumed);
    assign w_sat            = w_cred_sum > (CW+1)'(BUF_BEATS);
    assign credits          = r_credits;
    assign stall_cycles     = r_stall_cycles;
    assign zero_len_drops   = r_zero_len_drops;
    assign credit_err       = r_credit_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_pop ? CHECK : IDLE;
            CHECK:   w_state_nxt = w_zero ? IDLE : (w_fits ? ISSUE : CHECK);
            ISSUE:   w_state_nxt = ((!r_rd_pend || w_rd_hs) && (!r_meta_pend || w_meta_hs)) ? IDLE : ISSUE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_head           <= '0;
            r_beats          <= '0;
            r_rd_pend        <= 1'b0;
            r_meta_pend      <= 1'b0;
            r_credits        <= CW'(BUF_BEATS);
            r_stall_cycles   <= '0;
            r_zero_len_drops <= '0;
            r_credit_err     <= 1'b0;
        end else begin
            if (w_pop) begin
                r_head  <= w_fifo_data;
                r_beats <= len_to_beats(w_fifo_data[LEN_LSB +: LEN_W]);
            end
            r_rd_pend        <= w_debit || (r_rd_pend && !w_rd_hs);
            r_meta_pend      <= w_debit || (r_meta_pend && !w_meta_hs);
            r_credits        <= w_sat ? CW'(BUF_BEATS) : w_cred_sum[CW-1:0];
            r_credit_err     <= r_credit_err || w_sat;
            r_stall_cycles   <= r_stall_cycles + 32'(w_stall);
            r_zero_len_drops <= r_zero_len_drops + 32'((r_state == CHECK) && w_zero);
        end
    end
endmodule
